// File: rtl/difftest_batch_streamer.sv
// rtl/difftest_batch_streamer.sv - buffers wide difftest batch words and streams them as narrow beats
// Drops batches when full; every offered batch consumes a sequence number so the sink can see gaps.
module difftest_batch_streamer #(
  parameter int IN_W  = 1024,
  parameter int OUT_W = 256,
  parameter int DEPTH = 4,
  parameter int SEQ_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_enable,
  output logic             in_almost_full,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [OUT_W-1:0] m_tdata,
  output logic             m_tlast,
  output logic [SEQ_W-1:0] m_tuser,
  input  logic             clear_stats,
  output logic [31:0]      drop_cnt,
  output logic             overflow
);

  localparam int BEATS = IN_W / OUT_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE       = (AW + 1)'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_next;

  logic [IN_W-1:0]  data_mem [DEPTH];
  logic [SEQ_W-1:0] seq_mem  [DEPTH];

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ, occ_next;
  logic [BW-1:0]    beat;
  logic [SEQ_W-1:0] seq;
  logic             wr, drop, handshake, pop;
  logic [BEATS-1:0][OUT_W-1:0] head_beats;

  // Admission uses the registered occupancy only, so a same-cycle pop never frees a slot.
  assign wr        = in_enable && (occ != FULL);
  assign drop      = in_enable && (occ == FULL);
  assign handshake = m_tvalid && m_tready;
  assign pop       = handshake && (beat == LAST_BEAT);
  assign head_beats = data_mem[rd_ptr];

  assign m_tvalid       = (state == SEND);
  assign m_tlast        = m_tvalid && (beat == LAST_BEAT);
  assign m_tdata        = m_tvalid ? head_beats[beat] : '0;
  assign m_tuser        = m_tvalid ? seq_mem[rd_ptr] : '0;
  assign in_almost_full = (occ >= FULL - ONE);

  always_comb begin
    occ_next   = occ;
    state_next = state;
    case ({wr, pop})
      2'b10:   occ_next = occ + ONE;
      2'b01:   occ_next = occ - ONE;
      default: occ_next = occ;
    endcase
    // Entering SEND at the accepting edge puts beat 0 on the bus the very next cycle.
    case (state)
      IDLE:    if (occ_next != '0) state_next = SEND;
      SEND:    if (pop && (occ == ONE) && !wr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat     <= '0;
      seq      <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      occ   <= occ_next;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (in_enable) seq <= seq + 1'b1;
      if (handshake) begin
        if (beat == LAST_BEAT) begin
          beat   <= '0;
          rd_ptr <= rd_ptr + 1'b1;
        end else begin
          beat <= beat + 1'b1;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
        if (clear_stats)                   drop_cnt <= 32'd1;
        else if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
      end else if (clear_stats) begin
        drop_cnt <= '0;
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr) begin
      data_mem[wr_ptr] <= in_data;
      seq_mem[wr_ptr]  <= seq;
    end
  end

endmodule

// File: tb/tb_difftest_batch_streamer.sv
// tb/tb_difftest_batch_streamer.sv - self-checking bench for difftest_batch_streamer
// Scoreboard of expected beats plus a per-cycle table for occupancy and drop statistics.
module tb_difftest_batch_streamer;

  localparam int IN_W  = 1024;
  localparam int OUT_W = 256;
  localparam int DEPTH = 4;
  localparam int SEQ_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_enable = 1'b0;
  logic             in_almost_full;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic [OUT_W-1:0] m_tdata;
  logic             m_tlast;
  logic [SEQ_W-1:0] m_tuser;
  logic             clear_stats = 1'b0;
  logic [31:0]      drop_cnt;
  logic             overflow;

  difftest_batch_streamer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_enable(in_enable),
    .in_almost_full(in_almost_full), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tuser(m_tuser), .clear_stats(clear_stats),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
    logic [SEQ_W-1:0] user;
  } beat_t;

  typedef struct packed {
    logic        en;
    logic        clr;
    logic        acc;
    logic        af;
    logic [31:0] cnt;
    logic        ovf;
  } vec_t;

  beat_t            sb[$];
  vec_t             vecs[16];
  int               pass_cnt = 0;
  int               total_cnt = 0;
  logic [SEQ_W-1:0] tb_seq = '0;
  logic             rand_mode = 1'b0;
  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data;
  logic             prev_last;
  logic [SEQ_W-1:0] prev_user;

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [IN_W-1:0] mk_data(input int n);
    logic [IN_W-1:0] d;
    logic [15:0]     t;
    t = n[15:0];
    for (int k = 0; k < 4; k++) d[k*OUT_W +: OUT_W] = {8{t, 8'(k), 8'hC3}};
    return d;
  endfunction

  task automatic push_batch(input logic [IN_W-1:0] d, input logic [SEQ_W-1:0] s);
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      b.data = d[k*OUT_W +: OUT_W];
      b.last = (k == 3);
      b.user = s;
      sb.push_back(b);
    end
  endtask

  task automatic offer(input int n, input logic expect_accept);
    in_data   = mk_data(n);
    in_enable = 1'b1;
    if (expect_accept) push_batch(mk_data(n), tb_seq);
    tb_seq++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    tb_seq = '0;
    in_enable = 1'b0;
    clear_stats = 1'b0;
    m_tready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int c;
    c = 0;
    while (sb.size() != 0 && c < max_cyc) begin
      @(posedge clock);
      #1;
      c++;
    end
    check("drain_complete", OUT_W'(sb.size()), '0);
  endtask

  // Beat monitor: compares handshaken beats against the scoreboard and checks stall stability.
  always @(negedge clock) begin
    beat_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && m_tvalid) begin
        check("stall_tdata", m_tdata, prev_data);
        check("stall_tlast", m_tlast, prev_last);
        check("stall_tuser", m_tuser, prev_user);
      end
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_beat: got tuser %0d with no beat expected", m_tuser);
        end else begin
          e = sb.pop_front();
          check("beat_tdata", m_tdata, e.data);
          check("beat_tlast", m_tlast, e.last);
          check("beat_tuser", m_tuser, e.user);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      prev_user  = m_tuser;
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_mode) m_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    // en clr acc af cnt ovf, m_tready held low throughout
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0};
    for (int i = 4; i < 11; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'(i - 3), 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd1, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 1'b1};

    #3;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_almost_full", in_almost_full, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Single batch: beats on consecutive cycles, then back-to-back pair with no gap.
    m_tready = 1'b1;
    offer(1, 1'b1);
    @(posedge clock); #1;
    in_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("single_tvalid", m_tvalid, 1);
      check("single_tlast", m_tlast, (k == 3));
      @(posedge clock); #1;
    end
    check("single_idle_after", m_tvalid, 0);
    offer(2, 1'b1);
    @(posedge clock); #1;
    offer(3, 1'b1);
    @(posedge clock); #1;
    in_enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check("b2b_tvalid", m_tvalid, 1);
      @(posedge clock); #1;
    end
    check("b2b_idle_after", m_tvalid, 0);
    check("b2b_drained", OUT_W'(sb.size()), '0);

    // Per-cycle table: fill, drop, clear_stats, clear colliding with drop.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      clear_stats = vecs[i].clr;
      if (vecs[i].en) offer(16 + i, vecs[i].acc);
      else in_enable = 1'b0;
      @(posedge clock); #1;
      check("tbl_almost_full", in_almost_full, vecs[i].af);
      check("tbl_drop_cnt", drop_cnt, vecs[i].cnt);
      check("tbl_overflow", overflow, vecs[i].ovf);
      check("tbl_tvalid", m_tvalid, 1);
    end
    in_enable = 1'b0;
    clear_stats = 1'b0;
    m_tready = 1'b1;
    drain(100);

    // Full FIFO: write coinciding with last-beat pop must still drop.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      offer(40 + n, 1'b1);
      @(posedge clock); #1;
    end
    in_enable = 1'b0;
    m_tready = 1'b1;
    c = 0;
    while (!m_tlast && c < 20) begin
      @(posedge clock); #1;
      c++;
    end
    check("full_tlast_seen", m_tlast, 1);
    offer(99, 1'b0);
    @(posedge clock); #1;
    in_enable = 1'b0;
    m_tready = 1'b0;
    check("full_drop_cnt", drop_cnt, 1);
    check("full_overflow", overflow, 1);
    check("full_tuser_next", m_tuser, 1);
    offer(50, 1'b1);
    @(posedge clock); #1;
    in_enable = 1'b0;
    check("full_occ3_accept", drop_cnt, 1);
    check("full_almost_full", in_almost_full, 1);
    m_tready = 1'b1;
    drain(100);

    // Asynchronous reset during beat 2, then a fresh batch restarts at seq 0.
    do_reset();
    m_tready = 1'b1;
    offer(7, 1'b1);
    @(posedge clock); #1;
    in_enable = 1'b0;
    check("rst2_first_valid", m_tvalid, 1);
    check("rst2_beat0", m_tdata, mk_data(7)[OUT_W-1:0]);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rst2_beat2", m_tdata, mk_data(7)[3*OUT_W-1:2*OUT_W]);
    #2;
    reset = 1'b1;
    sb.delete();
    tb_seq = '0;
    #1;
    check("async_rst_tvalid", m_tvalid, 0);
    check("async_rst_tdata", m_tdata, 0);
    check("async_rst_tuser", m_tuser, 0);
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    offer(8, 1'b1);
    @(posedge clock); #1;
    in_enable = 1'b0;
    check("post_rst_valid", m_tvalid, 1);
    check("post_rst_tuser", m_tuser, 0);
    drain(100);

    // Random backpressure, 100 batches spaced 20 cycles apart.
    do_reset();
    rand_mode = 1'b1;
    for (int b = 0; b < 100; b++) begin
      offer(200 + b, 1'b1);
      @(posedge clock); #1;
      in_enable = 1'b0;
      repeat (19) @(posedge clock);
      #1;
    end
    drain(400);
    rand_mode = 1'b0;
    check("rand_drop_cnt", drop_cnt, 0);
    check("rand_overflow", overflow, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
